// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared encodings and constants for the OLED SPI transmitter
package oled_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic DC_CMD    = 1'b0;
    localparam logic DC_DATA   = 1'b1;
    localparam logic SCLK_IDLE = 1'b1;

    // Counter width able to hold 0..n, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/oled_spi_baud.sv
// rtl/oled_spi_baud.sv - SCLK half-period tick generator, restarted on every accepted byte
module oled_spi_baud
    import oled_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int W = cnt_width(CLK_DIV);

    logic [W-1:0] r_div_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_div_cnt <= '0;
        end else if (i_en) begin
            if (r_div_cnt == W'(CLK_DIV - 1)) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + W'(1);
            end
        end
    end

    // Tick on count zero so the first half-period starts the cycle after a clear
    assign o_tick = i_en & (r_div_cnt == '0);

endmodule

// File: rtl/oled_spi_tx.sv
// rtl/oled_spi_tx.sv - SSD1306 byte-level SPI transmitter; OLED_SPI_CS_EN adds a driven cs_n
module oled_spi_tx
    import oled_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_dc,
    output logic       o_tx_ready,
    output logic       o_busy,
    output logic       o_sclk,
    output logic       o_sdin,
`ifdef OLED_SPI_CS_EN
    output logic       o_cs_n,
`endif
    output logic       o_dc
);

    localparam int GW = cnt_width(GAP_CYCLES);

    state_t         r_state;
    logic [7:0]     r_shreg;
    logic [2:0]     r_bit_cnt;
    logic           r_last;
    logic [GW-1:0]  r_gap_cnt;
    logic           r_sclk;
    logic           r_sdin;
    logic           r_dc;
`ifdef OLED_SPI_CS_EN
    logic           r_cs_n;
`endif

    logic w_accept;
    logic w_shift;
    logic w_tick;

    assign o_tx_ready = (r_state == ST_IDLE) & ~rst;
    assign w_accept   = i_tx_valid & o_tx_ready;
    assign w_shift    = (r_state == ST_SHIFT);

    oled_spi_baud #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_accept),
        .i_en   (w_shift),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_last    <= 1'b0;
            r_gap_cnt <= '0;
            r_sclk    <= SCLK_IDLE;
            r_sdin    <= 1'b0;
            r_dc      <= DC_CMD;
`ifdef OLED_SPI_CS_EN
            r_cs_n    <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shreg   <= i_tx_data;
                        r_dc      <= i_tx_dc;
                        r_bit_cnt <= 3'd7;
                        r_last    <= 1'b0;
                        r_state   <= ST_SHIFT;
`ifdef OLED_SPI_CS_EN
                        r_cs_n    <= 1'b0;
`endif
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        if (!r_sclk) begin
                            // Rising edge: the panel samples the bit presented on the last fall
                            r_sclk <= 1'b1;
                            if (r_bit_cnt == 3'd0) begin
                                r_last <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt - 3'd1;
                            end
                        end else if (r_last) begin
                            r_gap_cnt <= '0;
                            r_state   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
`ifdef OLED_SPI_CS_EN
                            r_cs_n    <= 1'b1;
`endif
                        end else begin
                            r_sclk  <= 1'b0;
                            r_sdin  <= r_shreg[7];
                            r_shreg <= {r_shreg[6:0], 1'b0};
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy = (r_state != ST_IDLE);
    assign o_sclk = r_sclk;
    assign o_sdin = r_sdin;
    assign o_dc   = r_dc;
`ifdef OLED_SPI_CS_EN
    assign o_cs_n = r_cs_n;
`endif

endmodule

// File: tb/tb_oled_spi_tx.sv
// tb/tb_oled_spi_tx.sv - checks two oled_spi_tx builds (div2/gap2, div1/gap0) against a per-cycle timing model
module tb_oled_spi_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst;
    logic [1:0] tx_valid;
    logic [1:0] tx_dc;
    logic [7:0] tx_data [2];
    logic [1:0] tx_ready;
    logic [1:0] busy;
    logic [1:0] sclk;
    logic [1:0] sdin;
    logic [1:0] dc;
    logic [1:0] cs_n;

    int n_tests = 0;
    int n_fail  = 0;

    oled_spi_tx #(.CLK_DIV(2), .GAP_CYCLES(2)) u_a (
        .clk        (clk),
        .rst        (rst[0]),
        .i_tx_valid (tx_valid[0]),
        .i_tx_data  (tx_data[0]),
        .i_tx_dc    (tx_dc[0]),
        .o_tx_ready (tx_ready[0]),
        .o_busy     (busy[0]),
        .o_sclk     (sclk[0]),
        .o_sdin     (sdin[0]),
`ifdef OLED_SPI_CS_EN
        .o_cs_n     (cs_n[0]),
`endif
        .o_dc       (dc[0])
    );

    oled_spi_tx #(.CLK_DIV(1), .GAP_CYCLES(0)) u_b (
        .clk        (clk),
        .rst        (rst[1]),
        .i_tx_valid (tx_valid[1]),
        .i_tx_data  (tx_data[1]),
        .i_tx_dc    (tx_dc[1]),
        .o_tx_ready (tx_ready[1]),
        .o_busy     (busy[1]),
        .o_sclk     (sclk[1]),
        .o_sdin     (sdin[1]),
`ifdef OLED_SPI_CS_EN
        .o_cs_n     (cs_n[1]),
`endif
        .o_dc       (dc[1])
    );

`ifndef OLED_SPI_CS_EN
    assign cs_n = 2'b11;
`endif

    function automatic int div_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int gap_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[u%0d] at %0t: got %0h, expected %0h", name, inst, $time, act, exp);
        end
    endtask

    // Expected {sclk, sdin, busy, cs_n}; t counts clock edges since the accepting edge
    function automatic logic [3:0] exp_out(input int d, input bit act, input int t,
                                           input logic [7:0] b, input logic prev);
        int p;
        if (!act)       return {1'b1, prev, 1'b0, 1'b1};
        if (t == 0)     return {1'b1, prev, 1'b1, 1'b0};
        if (t <= 16*d) begin
            p = (t - 1) / d;
            return {(p % 2 == 1), b[7 - p/2], 1'b1, 1'b0};
        end
        return {1'b1, b[0], 1'b1, 1'b1};
    endfunction

    bit         m_active [2];
    int         m_t      [2];
    logic [7:0] m_byte   [2];
    logic       m_dc     [2];
    logic       m_sdin   [2];
    int         rises    [2];
    logic [15:0] cap     [2];
    logic       prev_sclk[2];
    logic [3:0] e_out;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                m_active[i] = 1'b0;
                m_sdin[i]   = 1'b0;
                m_dc[i]     = 1'b0;
            end else if (!m_active[i]) begin
                if (tx_valid[i]) begin
                    m_active[i] = 1'b1;
                    m_t[i]      = 0;
                    m_byte[i]   = tx_data[i];
                    m_dc[i]     = tx_dc[i];
                end
            end else begin
                m_t[i]++;
                if (m_t[i] == 16*div_of(i) + gap_of(i) + 1) begin
                    m_active[i] = 1'b0;
                    m_sdin[i]   = m_byte[i][0];
                end
            end
        end
        #2;
        for (int i = 0; i < 2; i++) begin
            e_out = exp_out(div_of(i), m_active[i], m_t[i], m_byte[i], m_sdin[i]);
            chk("sclk",  i, sclk[i],     e_out[3]);
            chk("sdin",  i, sdin[i],     e_out[2]);
            chk("busy",  i, busy[i],     e_out[1]);
            chk("ready", i, tx_ready[i], !m_active[i] && !rst[i]);
            chk("dc",    i, dc[i],       m_dc[i]);
`ifdef OLED_SPI_CS_EN
            chk("cs_n",  i, cs_n[i],     e_out[0]);
`endif
            if (!prev_sclk[i] && sclk[i]) begin
                rises[i]++;
                cap[i] = {cap[i][14:0], sdin[i]};
            end
            prev_sclk[i] = sclk[i];
        end
    end

    task automatic offer(input int i, input logic [7:0] b, input logic d);
        int k = 0;
        tx_data[i]  = b;
        tx_dc[i]    = d;
        tx_valid[i] = 1'b1;
        while (!tx_ready[i] && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("accept_wait", i, (k < 300), 1);
        @(posedge clk);
    endtask

    task automatic drop_and_latency(input int i, output int lat);
        @(negedge clk);
        tx_valid[i] = 1'b0;
        lat = 0;
        while (!tx_ready[i] && lat < 300) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0, r1, lat, k, hi;
        bit seen;
        for (int i = 0; i < 2; i++) begin
            m_active[i]  = 1'b0;
            m_t[i]       = 0;
            m_byte[i]    = 8'h00;
            m_dc[i]      = 1'b0;
            m_sdin[i]    = 1'b0;
            rises[i]     = 0;
            cap[i]       = 16'h0;
            prev_sclk[i] = 1'b1;
            tx_data[i]   = 8'h00;
        end
        rst      = 2'b11;
        tx_valid = 2'b00;
        tx_dc    = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_ready", 0, tx_ready[0], 0);
        chk("rst_sclk",  0, sclk[0], 1);
        chk("rst_busy",  0, busy[0], 0);
        chk("rst_sdin",  1, sdin[1], 0);
        rst = 2'b00;
        @(negedge clk);

        // 0xA5 command byte
        r0 = rises[0];
        offer(0, 8'hA5, 1'b0);
        drop_and_latency(0, lat);
        chk("t1_latency", 0, lat, 35);
        chk("t1_rises",   0, rises[0] - r0, 8);
        chk("t1_bits",    0, cap[0][7:0], 8'hA5);
        chk("t1_dc",      0, dc[0], 0);

        // back-to-back, valid held
        r0 = rises[0];
        offer(0, 8'hAF, 1'b0);
        @(negedge clk);
        tx_data[0] = 8'h3C;
        tx_dc[0]   = 1'b1;
        chk("t2_dc_first", 0, dc[0], 0);
        offer(0, 8'h3C, 1'b1);
        drop_and_latency(0, lat);
        chk("t2_latency", 0, lat, 35);
        chk("t2_rises",   0, rises[0] - r0, 16);
        chk("t2_bits",    0, cap[0], 16'hAF3C);
        chk("t2_dc_last", 0, dc[0], 1);

        // valid pulse while busy is ignored
        r0 = rises[0];
        offer(0, 8'h00, 1'b0);
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (5) @(negedge clk);
        tx_data[0]  = 8'hFF;
        tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        k = 0;
        while (!tx_ready[0] && k < 300) begin @(negedge clk); k++; end
        chk("t3_rises", 0, rises[0] - r0, 8);
        chk("t3_bits",  0, cap[0][7:0], 8'h00);

        // reset mid-byte, then a clean resend
        r0 = rises[0];
        offer(0, 8'h81, 1'b0);
        @(negedge clk);
        tx_valid[0] = 1'b0;
        k = 0;
        while ((rises[0] - r0) < 4 && k < 200) begin @(negedge clk); k++; end
        chk("t4_wait", 0, (k < 200), 1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("t4_sclk", 0, sclk[0], 1);
        chk("t4_sdin", 0, sdin[0], 0);
        chk("t4_busy", 0, busy[0], 0);
        r1 = rises[0];
        repeat (40) @(negedge clk);
        chk("t4_no_edges", 0, rises[0] - r1, 0);
        offer(0, 8'h81, 1'b0);
        drop_and_latency(0, lat);
        chk("t4_rises", 0, rises[0] - r1, 8);
        chk("t4_bits",  0, cap[0][7:0], 8'h81);

        // CLK_DIV=1, GAP_CYCLES=0
        r0 = rises[1];
        offer(1, 8'h01, 1'b1);
        drop_and_latency(1, lat);
        chk("t5_latency",  1, lat, 17);
        chk("t5_rises",    1, rises[1] - r0, 8);
        chk("t5_bits",     1, cap[1][7:0], 8'h01);
        chk("t5_last_bit", 1, cap[1][0], 1);
        chk("t5_dc",       1, dc[1], 1);

`ifdef OLED_SPI_CS_EN
        // cs_n deasserted for the gap between two back-to-back bytes
        r0 = rises[0];
        offer(0, 8'h55, 1'b0);
        @(negedge clk);
        tx_data[0] = 8'hAA;
        tx_dc[0]   = 1'b1;
        hi = 0;
        seen = 1'b0;
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (cs_n[0]) begin
                seen = 1'b1;
                if (busy[0]) hi++;
            end else if (seen) begin
                break;
            end
        end
        tx_valid[0] = 1'b0;
        chk("t6_wait",    0, (k < 200), 1);
        chk("t6_cs_high", 0, hi, 2);
        k = 0;
        while (!tx_ready[0] && k < 300) begin @(negedge clk); k++; end
        chk("t6_rises", 0, rises[0] - r0, 16);
        chk("t6_bits",  0, cap[0], 16'h55AA);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
